ifu_fetch: RTL

Instruction fetch stage of the NPC core, directly upstream of the control/decode stage. Holds the architectural PC, issues one outstanding request at a time to instruction memory over a valid/ready handshake, and presents each fetched instruction plus its PC to decode with a valid/ready handshake. It accepts PC redirects from branch/jump resolution at any time. It also provides a halt input and a sticky misalignment error.

---
 rtl/ifu_fetch.sv | 83 ++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage, one outstanding imem request, PC redirect,
// halt gating and a sticky misaligned-redirect error.
module ifu_fetch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            fetch_err
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, inst_pc_q, inst_pc_d;
  logic [31:0] inst_q, inst_d;
  logic drop_q, drop_d;
  logic hs, mis, inflight;
  assign imem_req_valid = state_q == S_REQ && !halt_req;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = state_q == S_HOLD;
  assign fetch_err      = state_q == S_ERR;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign hs             = imem_req_valid && imem_req_ready;
  assign mis            = |redirect_pc[1:0];
  // an old-PC request is still outstanding after this cycle
  assign inflight       = hs || (state_q == S_WAIT && !imem_resp_valid);
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_REQ:  state_d = hs ? S_WAIT : S_REQ;
      S_WAIT: if (imem_resp_valid) begin
        state_d   = drop_q ? S_REQ : S_HOLD;
        drop_d    = 1'b0;
        inst_d    = drop_q ? inst_q : imem_resp_data;
        inst_pc_d = drop_q ? inst_pc_q : pc_q;
      end
      S_HOLD: if (inst_ready) begin
        pc_d    = pc_q + XLEN'(4);
        state_d = S_REQ;
      end
      default: ;
    endcase
    // redirect overrides every other event except the sticky error
    if (redirect_valid && state_q != S_ERR) begin
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      pc_d      = mis ? pc_q : redirect_pc;
      state_d   = mis ? S_ERR : (inflight ? S_WAIT : S_REQ);
      drop_d    = !mis && inflight;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= 32'h0000_0013;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end
endmodule
